// File: rtl/comp_div_pkg.sv
// comp_div_pkg -- shared definitions for the complex divider.
//   state_t : FSM state encoding (IDLE -> MULT -> PREP -> DIV -> OUT).
//   latency : cycles from the accept edge to the o_valid_data edge,
//             for a given output width and rounding option.
package comp_div_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        PREP = 3'd2,
        DIV  = 3'd3,
        OUT  = 3'd4
    } state_t;

    // Accept edge to result strobe: MULT + PREP + DIV (one cycle per quotient bit) + OUT.
    function automatic int unsigned latency(input int unsigned out_w, input bit round_en);
        return out_w + 32'd3 + (round_en ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/comp_div_serial_udiv.sv
// serial_udiv -- unsigned restoring divider, one quotient bit per clock.
// Only the low QW quotient bits are produced: the caller guarantees
// dividend < divisor << QW, so the dividend bits above the low QW bits
// form a valid starting partial remainder.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load dividend/divisor and begin (one-cycle pulse)
//   dividend   : DW-bit unsigned dividend
//   divisor    : VW-bit unsigned divisor
//   quotient   : QW-bit quotient, complete when done is high
//   done       : one-cycle strobe in the cycle after the last quotient bit
module serial_udiv #(
    parameter int DW = 53,
    parameter int VW = 36,
    parameter int QW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [QW-1:0] quotient,
    output logic          done
);

    localparam int EW   = (DW > VW + QW) ? DW : VW + QW;
    localparam int CNTW = $clog2(QW + 1);

    logic [VW-1:0]   rem_r;
    logic [QW-1:0]   low_r;
    logic [VW-1:0]   div_r;
    logic [CNTW-1:0] cnt_r;
    logic            busy_r;
    logic            done_r;

    logic [VW:0]     trial_s;
    logic            fits_s;
    logic [VW-1:0]   next_rem_s;

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    always_comb begin
        trial_s    = {rem_r, low_r[QW-1]};
        fits_s     = (trial_s >= {1'b0, div_r});
        if (fits_s) begin
            next_rem_s = VW'(trial_s - {1'b0, div_r});
        end else begin
            next_rem_s = trial_s[VW-1:0];
        end
    end

    // Iteration registers: low_r shifts dividend bits out and quotient bits in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r  <= {VW{1'b0}};
            low_r  <= {QW{1'b0}};
            div_r  <= {VW{1'b0}};
            cnt_r  <= {CNTW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            rem_r  <= VW'(EW'(dividend) >> QW);
            low_r  <= dividend[QW-1:0];
            div_r  <= divisor;
            cnt_r  <= CNTW'(QW);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            rem_r  <= next_rem_s;
            low_r  <= {low_r[QW-2:0], fits_s};
            cnt_r  <= cnt_r - CNTW'(1);
            busy_r <= (cnt_r != CNTW'(1));
            done_r <= (cnt_r == CNTW'(1));
        end else begin
            done_r <= 1'b0;
        end
    end

    assign quotient = low_r;
    assign done     = done_r;

endmodule

// File: rtl/comp_div.sv
// comp_div -- fixed-point complex divider (a+jb)/(c+jd).
// The quotient carries FRAC_BITS fractional bits; overflow either saturates
// (WRAP_SATURATE=1) or wraps (WRAP_SATURATE=0).
// Optional feature: define COMP_DIV_ROUND_EN to compute one extra quotient
// bit and round half away from zero (one extra DIV cycle).
// Ports:
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_a, i_b             : numerator real / imaginary (signed)
//   i_c, i_d             : denominator real / imaginary (signed)
//   i_valid_data         : operands valid; taken when o_ready is high
//   o_ready              : block idle
//   o_r, o_im            : quotient real / imaginary (signed)
//   o_valid_data         : one-cycle result strobe
//   o_div_by_zero        : denominator was 0+j0 (qualified by o_valid_data)
module comp_div
    import comp_div_pkg::*;
#(
    parameter int INPUT_WIDTH   = 18,
    parameter int OUTPUT_WIDTH  = 18,
    parameter int FRAC_BITS     = 16,
    parameter int WRAP_SATURATE = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic signed [INPUT_WIDTH-1:0]  i_a,
    input  logic signed [INPUT_WIDTH-1:0]  i_b,
    input  logic signed [INPUT_WIDTH-1:0]  i_c,
    input  logic signed [INPUT_WIDTH-1:0]  i_d,
    input  logic                           i_valid_data,
    output logic                           o_ready,
    output logic signed [OUTPUT_WIDTH-1:0] o_r,
    output logic signed [OUTPUT_WIDTH-1:0] o_im,
    output logic                           o_valid_data,
    output logic                           o_div_by_zero
);

`ifdef COMP_DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    localparam int PW   = 2 * INPUT_WIDTH;                 // product width
    localparam int NW   = PW + 1;                          // numerator sum width
    localparam int DENW = PW;                              // c^2 + d^2 width
    localparam int QW   = OUTPUT_WIDTH + RND;              // quotient bits
    localparam int XW   = NW + FRAC_BITS + RND;            // dividend width
    localparam int CW   = NW + FRAC_BITS + DENW + OUTPUT_WIDTH;
    localparam int CNTW = $clog2(QW + 1);
    localparam int MW1  = OUTPUT_WIDTH + 1;

    state_t state_r;
    state_t state_s;

    logic signed [INPUT_WIDTH-1:0] a_r, b_r, c_r, d_r;
    logic signed [PW-1:0]          ac_r, bd_r, bc_r, ad_r;
    logic [DENW-1:0]               cc_r, dd_r;
    logic [CNTW-1:0]               div_cnt_r;
    logic                          neg_re_r, neg_im_r;
    logic                          povf_re_r, povf_im_r;
    logic                          zero_r;

    logic signed [PW-1:0]          a_x_s, b_x_s, c_x_s, d_x_s;
    logic signed [PW-1:0]          cc_x_s, dd_x_s;
    logic signed [NW-1:0]          re_s, im_s;
    logic [NW-1:0]                 re_mag_s, im_mag_s;
    logic [DENW-1:0]               den_s;
    logic [XW-1:0]                 re_div_s, im_div_s;
    logic                          povf_re_s, povf_im_s;
    logic                          start_s;
    logic [QW-1:0]                 q_re_s, q_im_s;
    logic                          done_re_s, done_im_s;

    // Optional rounding, sign application and overflow handling of one quotient.
    function automatic logic [OUTPUT_WIDTH-1:0] finish_q(input logic [QW-1:0] q,
                                                         input logic          num_neg,
                                                         input logic          pre_ovf);
        logic [MW1-1:0]          mag;
        logic [MW1-1:0]          pos_lim;
        logic [MW1-1:0]          neg_lim;
        logic                    neg;
        logic                    ovf;
        logic [OUTPUT_WIDTH-1:0] res;
        pos_lim = {2'b00, {(OUTPUT_WIDTH-1){1'b1}}};
        neg_lim = {2'b01, {(OUTPUT_WIDTH-1){1'b0}}};
        if (RND == 1) begin
            // q holds twice the quotient; adding its LSB rounds the half up in magnitude.
            mag = MW1'(q >> 1) + MW1'(q[0]);
        end else begin
            mag = MW1'(q);
        end
        neg = num_neg && (mag != {MW1{1'b0}});
        if (neg) begin
            ovf = pre_ovf || (mag > neg_lim);
        end else begin
            ovf = pre_ovf || (mag > pos_lim);
        end
        if (ovf && (WRAP_SATURATE != 0)) begin
            if (neg) begin
                res = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
            end else begin
                res = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
            end
        end else if (neg) begin
            res = OUTPUT_WIDTH'(~mag + MW1'(1'b1));
        end else begin
            // In wrap mode a precheck overflow keeps only the bits the serial divider produced.
            res = OUTPUT_WIDTH'(mag);
        end
        return res;
    endfunction

    // Sign-extended operands, products, sums, magnitudes and overflow precheck.
    always_comb begin
        a_x_s     = PW'(a_r);
        b_x_s     = PW'(b_r);
        c_x_s     = PW'(c_r);
        d_x_s     = PW'(d_r);
        cc_x_s    = c_x_s * c_x_s;
        dd_x_s    = d_x_s * d_x_s;
        re_s      = NW'(ac_r) + NW'(bd_r);
        im_s      = NW'(bc_r) - NW'(ad_r);
        den_s     = cc_r + dd_r;
        if (re_s[NW-1]) begin
            re_mag_s = $unsigned(-re_s);
        end else begin
            re_mag_s = $unsigned(re_s);
        end
        if (im_s[NW-1]) begin
            im_mag_s = $unsigned(-im_s);
        end else begin
            im_mag_s = $unsigned(im_s);
        end
        re_div_s  = XW'(re_mag_s) << (FRAC_BITS + RND);
        im_div_s  = XW'(im_mag_s) << (FRAC_BITS + RND);
        // Quotient would need more than OUTPUT_WIDTH integer-plus-fraction bits.
        povf_re_s = (CW'(re_mag_s) << FRAC_BITS) >= (CW'(den_s) << OUTPUT_WIDTH);
        povf_im_s = (CW'(im_mag_s) << FRAC_BITS) >= (CW'(den_s) << OUTPUT_WIDTH);
        start_s   = (state_r == PREP);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_valid_data) begin
                    state_s = MULT;
                end else begin
                    state_s = IDLE;
                end
            end
            MULT: state_s = PREP;
            PREP: state_s = DIV;
            DIV: begin
                if (div_cnt_r == CNTW'(QW - 1)) begin
                    state_s = OUT;
                end else begin
                    state_s = DIV;
                end
            end
            OUT:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, products (MULT), sign/precheck flags (PREP) and DIV cycle count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_r       <= {INPUT_WIDTH{1'b0}};
            b_r       <= {INPUT_WIDTH{1'b0}};
            c_r       <= {INPUT_WIDTH{1'b0}};
            d_r       <= {INPUT_WIDTH{1'b0}};
            ac_r      <= {PW{1'b0}};
            bd_r      <= {PW{1'b0}};
            bc_r      <= {PW{1'b0}};
            ad_r      <= {PW{1'b0}};
            cc_r      <= {DENW{1'b0}};
            dd_r      <= {DENW{1'b0}};
            neg_re_r  <= 1'b0;
            neg_im_r  <= 1'b0;
            povf_re_r <= 1'b0;
            povf_im_r <= 1'b0;
            zero_r    <= 1'b0;
            div_cnt_r <= {CNTW{1'b0}};
        end else begin
            if ((state_r == IDLE) && i_valid_data) begin
                a_r <= i_a;
                b_r <= i_b;
                c_r <= i_c;
                d_r <= i_d;
            end
            if (state_r == MULT) begin
                ac_r <= a_x_s * c_x_s;
                bd_r <= b_x_s * d_x_s;
                bc_r <= b_x_s * c_x_s;
                ad_r <= a_x_s * d_x_s;
                cc_r <= $unsigned(cc_x_s);
                dd_r <= $unsigned(dd_x_s);
            end
            if (state_r == PREP) begin
                neg_re_r  <= re_s[NW-1];
                neg_im_r  <= im_s[NW-1];
                povf_re_r <= povf_re_s;
                povf_im_r <= povf_im_s;
                zero_r    <= (den_s == {DENW{1'b0}});
                div_cnt_r <= {CNTW{1'b0}};
            end else if (state_r == DIV) begin
                div_cnt_r <= div_cnt_r + CNTW'(1);
            end
        end
    end

    serial_udiv #(.DW(XW), .VW(DENW), .QW(QW)) u_div_re (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .start    (start_s),
        .dividend (re_div_s),
        .divisor  (den_s),
        .quotient (q_re_s),
        .done     (done_re_s)
    );

    serial_udiv #(.DW(XW), .VW(DENW), .QW(QW)) u_div_im (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .start    (start_s),
        .dividend (im_div_s),
        .divisor  (den_s),
        .quotient (q_im_s),
        .done     (done_im_s)
    );

    // Result registers: loaded once at the end of OUT, held until the next strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_data  <= 1'b0;
            o_r           <= {OUTPUT_WIDTH{1'b0}};
            o_im          <= {OUTPUT_WIDTH{1'b0}};
            o_div_by_zero <= 1'b0;
        end else if ((state_r == OUT) && done_re_s && done_im_s) begin
            o_valid_data  <= 1'b1;
            o_div_by_zero <= zero_r;
            if (zero_r) begin
                o_r  <= {OUTPUT_WIDTH{1'b0}};
                o_im <= {OUTPUT_WIDTH{1'b0}};
            end else begin
                o_r  <= finish_q(q_re_s, neg_re_r, povf_re_r);
                o_im <= finish_q(q_im_s, neg_im_r, povf_im_r);
            end
        end else begin
            o_valid_data <= 1'b0;
        end
    end

    assign o_ready = (state_r == IDLE);

endmodule

// File: tb/tb_comp_div.sv
// tb_comp_div -- scoreboard bench for comp_div at default parameters.
// Expected quotients come from exact integer arithmetic on a+jb, c+jd.
module tb_comp_div;

`ifdef COMP_DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam longint LAT = 21 + RND;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [17:0] a = 18'sd0, b = 18'sd0, c = 18'sd0, d = 18'sd0;
    logic               valid = 1'b0;
    logic               o_ready;
    logic signed [17:0] o_r, o_im;
    logic               o_valid_data;
    logic               o_div_by_zero;

    typedef struct {
        int     r;
        int     im;
        bit     dz;
        longint acc;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bit     prev_v = 1'b0;

    comp_div dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_a           (a),
        .i_b           (b),
        .i_c           (c),
        .i_d           (d),
        .i_valid_data  (valid),
        .o_ready       (o_ready),
        .o_r           (o_r),
        .o_im          (o_im),
        .o_valid_data  (o_valid_data),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Exact quotient n/den in Q.16, truncated or rounded, then saturated to 18 bits.
    function automatic int scale(input longint n, input longint den);
        longint mag, x, q;
        mag = (n < 0) ? -n : n;
        x   = mag * 65536;
        if (RND == 1) q = (2 * x / den + 1) / 2;
        else          q = x / den;
        if (q == 0) return 0;
        if (n < 0) return (q > 131072) ? -131072 : -int'(q);
        return (q > 131071) ? 131071 : int'(q);
    endfunction

    function automatic exp_t model(input int va, input int vb, input int vc, input int vd);
        exp_t   e;
        longint nr, ni, den;
        nr  = longint'(va) * vc + longint'(vb) * vd;
        ni  = longint'(vb) * vc - longint'(va) * vd;
        den = longint'(vc) * vc + longint'(vd) * vd;
        if (den == 0) begin
            e.r = 0; e.im = 0; e.dz = 1'b1;
        end else begin
            e.r = scale(nr, den); e.im = scale(ni, den); e.dz = 1'b0;
        end
        e.acc = 0;
        return e;
    endfunction

    // Wait (bounded) for o_ready, present one operand for one cycle, record expectation.
    task automatic issue(input int va, input int vb, input int vc, input int vd);
        int   n = 0;
        exp_t e;
        while (o_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (o_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got o_ready=%b expected 1", o_ready);
            return;
        end
        a = 18'(va); b = 18'(vb); c = 18'(vc); d = 18'(vd);
        valid = 1'b1;
        e = model(va, vb, vc, vd);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        valid = 1'b0;
        check("ready_low_after_accept", o_ready, 0);
    endtask

    // Monitor: pop and compare on every result strobe.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_valid_data) begin
            check("strobe_width", prev_v, 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got r=%0d im=%0d expected no strobe", o_r, o_im);
            end else begin
                e = sb.pop_front();
                check("o_r", o_r, e.r);
                check("o_im", o_im, e.im);
                check("o_div_by_zero", o_div_by_zero, e.dz);
                check("latency", cyc - e.acc, LAT);
                check("ready_at_strobe", o_ready, 1);
            end
        end
        prev_v = o_valid_data;
    end

    initial begin
        int k;
        int mode;
        int va, vb, vc, vd;

        repeat (3) @(negedge clk);
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid_data, 0);
        check("rst_r", o_r, 0);
        check("rst_im", o_im, 0);
        check("rst_dz", o_div_by_zero, 0);
        rst_n = 1'b1;

        // Directed cases, including saturation and zero denominator.
        issue(1, 0, 1, 0);
        issue(0, 2, 1, 1);
        issue(3, 0, 1, 0);
        issue(-3, 0, 1, 0);
        issue(5, 7, 0, 0);
        issue(2, 0, 3, 0);
        issue(-2, 0, 3, 0);
        issue(-131072, -131072, -131072, -131072);
        issue(131071, -131072, 1, 0);
        issue(1, -1, 131071, -131072);

        // A second operand presented during DIV must be ignored.
        issue(7, -3, 2, 5);
        repeat (4) @(negedge clk);
        a = 18'sd11; b = 18'sd12; c = 18'sd1; d = 18'sd0;
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("ready_low_busy", o_ready, 0);
            @(negedge clk);
        end
        valid = 1'b0;

        // Reset pulse mid-operation: no result, outputs cleared, then normal operation.
        issue(1, 0, 1, 0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_ready", o_ready, 1);
        check("midrst_valid", o_valid_data, 0);
        check("midrst_r", o_r, 0);
        check("midrst_im", o_im, 0);
        check("midrst_dz", o_div_by_zero, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(-5, 9, 3, -4);

        // Randomized operands: full range, tiny denominators, small values.
        for (int i = 0; i < 30; i++) begin
            mode = int'($urandom_range(0, 2));
            va = int'($urandom_range(0, 262143)) - 131072;
            vb = int'($urandom_range(0, 262143)) - 131072;
            if (mode == 0) begin
                vc = int'($urandom_range(0, 262143)) - 131072;
                vd = int'($urandom_range(0, 262143)) - 131072;
            end else if (mode == 1) begin
                vc = int'($urandom_range(0, 8)) - 4;
                vd = int'($urandom_range(0, 8)) - 4;
            end else begin
                va = int'($urandom_range(0, 40)) - 20;
                vb = int'($urandom_range(0, 40)) - 20;
                vc = int'($urandom_range(0, 40)) - 20;
                vd = int'($urandom_range(0, 40)) - 20;
            end
            issue(va, vb, vc, vd);
        end

        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain", sb.size(), 0);
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
